// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: ALU opcodes, operand selects, control bundle, forwarding select.
package riscv_pkg;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_SLL  = 5'd2,
    ALU_SLT  = 5'd3,
    ALU_SLTU = 5'd4,
    ALU_XOR  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_OR   = 5'd8,
    ALU_AND  = 5'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    ASEL_RS1  = 2'd0,
    ASEL_PC   = 2'd1,
    ASEL_ZERO = 2'd2
  } asel_t;

  typedef enum logic {
    BSEL_RS2 = 1'b0,
    BSEL_IMM = 1'b1
  } bsel_t;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
    logic branch;
  } ctrl_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EXM = 2'd1,
    FWD_MWB = 2'd2
  } fwd_sel_t;

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// Operand forwarding select for rs1/rs2; the younger EX/MEM result wins over MEM/WB.
module forward_unit
  import riscv_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_rs1,
  input  logic [REG_AW-1:0] i_rs2,
  input  logic              i_exm_regwrite,
  input  logic [REG_AW-1:0] i_exm_rd,
  input  logic              i_mwb_regwrite,
  input  logic [REG_AW-1:0] i_mwb_rd,
  output fwd_sel_t          o_sel_rs1,
  output fwd_sel_t          o_sel_rs2
);

  // x0 is hardwired zero, so a write "to" it must never be forwarded.
  function automatic fwd_sel_t pick(input logic [REG_AW-1:0] rs);
    if (i_exm_regwrite && i_exm_rd == rs && rs != '0)      return FWD_EXM;
    else if (i_mwb_regwrite && i_mwb_rd == rs && rs != '0) return FWD_MWB;
    else                                                   return FWD_RF;
  endfunction

  assign o_sel_rs1 = pick(i_rs1);
  assign o_sel_rs2 = pick(i_rs2);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, ALU operand muxes and load-use detect.
// ID_EX_FORWARDING_EN: enables forwarding; without it RAW hazards are resolved by stalling.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter int               REG_AW   = 5,
  parameter logic [XLEN-1:0]  PC_RESET = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [XLEN-1:0]   id_rs1_data_i,
  input  logic [XLEN-1:0]   id_rs2_data_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic [4:0]        id_alu_ctrl_i,
  input  logic [1:0]        id_asel_i,
  input  logic              id_bsel_i,
  input  logic [4:0]        id_ctrl_i,
  input  logic              exm_regwrite_i,
  input  logic [REG_AW-1:0] exm_rd_i,
  input  logic [XLEN-1:0]   exm_data_i,
  input  logic              mwb_regwrite_i,
  input  logic [REG_AW-1:0] mwb_rd_i,
  input  logic [XLEN-1:0]   mwb_data_i,
  output logic [XLEN-1:0]   A_alu,
  output logic [XLEN-1:0]   B_alu,
  output logic [4:0]        control_alu,
  output logic              ex_valid_o,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [XLEN-1:0]   ex_store_data_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic [4:0]        ex_ctrl_o,
  output logic              load_use_stall_o
);

  logic              r_valid;
  logic [XLEN-1:0]   r_pc, r_rs1_data, r_rs2_data, r_imm;
  logic [REG_AW-1:0] r_rs1, r_rs2, r_rd;
  logic [4:0]        r_alu_ctrl;
  logic [1:0]        r_asel;
  logic              r_bsel;
  ctrl_t             r_ctrl;

  logic [XLEN-1:0]   w_fwd_rs1, w_fwd_rs2;
  logic              w_load_use;

  always_ff @(posedge CLK) begin
    if (!RST_n || flush_i) begin
      r_valid    <= 1'b0;
      r_pc       <= RST_n ? '0 : PC_RESET;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_alu_ctrl <= '0;
      r_asel     <= '0;
      r_bsel     <= 1'b0;
      r_ctrl     <= '0;
    end else if (!stall_i) begin
      r_valid    <= id_valid_i;
      r_pc       <= id_pc_i;
      r_rs1_data <= id_rs1_data_i;
      r_rs2_data <= id_rs2_data_i;
      r_imm      <= id_imm_i;
      r_rs1      <= id_rs1_i;
      r_rs2      <= id_rs2_i;
      r_rd       <= id_valid_i ? id_rd_i : '0;
      r_alu_ctrl <= id_alu_ctrl_i;
      r_asel     <= id_asel_i;
      r_bsel     <= id_bsel_i;
      r_ctrl     <= id_valid_i ? id_ctrl_i : '0;
    end
  end

  // A load in EX cannot feed its consumer in decode even with forwarding.
  assign w_load_use = r_valid && r_ctrl.memread && r_rd != '0 &&
                      (r_rd == id_rs1_i || r_rd == id_rs2_i);

`ifdef ID_EX_FORWARDING_EN
  fwd_sel_t w_sel_rs1, w_sel_rs2;

  forward_unit #(.REG_AW(REG_AW)) u_fwd (
    .i_rs1          (r_rs1),
    .i_rs2          (r_rs2),
    .i_exm_regwrite (exm_regwrite_i),
    .i_exm_rd       (exm_rd_i),
    .i_mwb_regwrite (mwb_regwrite_i),
    .i_mwb_rd       (mwb_rd_i),
    .o_sel_rs1      (w_sel_rs1),
    .o_sel_rs2      (w_sel_rs2)
  );

  always_comb begin
    w_fwd_rs1 = r_rs1_data;
    w_fwd_rs2 = r_rs2_data;
    case (w_sel_rs1)
      FWD_EXM: w_fwd_rs1 = exm_data_i;
      FWD_MWB: w_fwd_rs1 = mwb_data_i;
      default: w_fwd_rs1 = r_rs1_data;
    endcase
    case (w_sel_rs2)
      FWD_EXM: w_fwd_rs2 = exm_data_i;
      FWD_MWB: w_fwd_rs2 = mwb_data_i;
      default: w_fwd_rs2 = r_rs2_data;
    endcase
  end

  assign load_use_stall_o = w_load_use;
`else
  logic w_raw_ex, w_raw_exm, w_raw_mwb;
  logic w_unused;

  assign w_fwd_rs1 = r_rs1_data;
  assign w_fwd_rs2 = r_rs2_data;
  assign w_unused  = ^{exm_data_i, mwb_data_i, r_rs1, r_rs2};

  // Every in-flight writer is a hazard for the decode slot when nothing forwards.
  assign w_raw_ex  = r_valid && r_ctrl.regwrite && r_rd != '0 &&
                     (r_rd == id_rs1_i || r_rd == id_rs2_i);
  assign w_raw_exm = exm_regwrite_i && exm_rd_i != '0 &&
                     (exm_rd_i == id_rs1_i || exm_rd_i == id_rs2_i);
  assign w_raw_mwb = mwb_regwrite_i && mwb_rd_i != '0 &&
                     (mwb_rd_i == id_rs1_i || mwb_rd_i == id_rs2_i);

  assign load_use_stall_o = w_load_use || w_raw_ex || w_raw_exm || w_raw_mwb;
`endif

  always_comb begin
    A_alu = '0;
    case (r_asel)
      ASEL_RS1: A_alu = w_fwd_rs1;
      ASEL_PC:  A_alu = r_pc;
      default:  A_alu = '0;
    endcase
  end

  assign B_alu           = (r_bsel == BSEL_IMM) ? r_imm : w_fwd_rs2;
  assign ex_store_data_o = w_fwd_rs2;
  assign control_alu     = r_alu_ctrl;
  assign ex_valid_o      = r_valid;
  assign ex_pc_o         = r_pc;
  assign ex_rd_o         = r_rd;
  assign ex_ctrl_o       = r_ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; expectations follow ID_EX_FORWARDING_EN when defined.
module tb_id_ex_stage;

`ifdef ID_EX_FORWARDING_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif
  localparam logic [31:0] PCR = 32'h0000_0100;

  logic        CLK = 1'b0;
  logic        RST_n, stall_i, flush_i, id_valid_i;
  logic [31:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i, id_alu_ctrl_i, id_ctrl_i;
  logic [1:0]  id_asel_i;
  logic        id_bsel_i;
  logic        exm_regwrite_i, mwb_regwrite_i;
  logic [4:0]  exm_rd_i, mwb_rd_i;
  logic [31:0] exm_data_i, mwb_data_i;
  logic [31:0] A_alu, B_alu, ex_pc_o, ex_store_data_o;
  logic [4:0]  control_alu, ex_rd_o, ex_ctrl_o;
  logic        ex_valid_o, load_use_stall_o;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  id_ex_stage #(.XLEN(32), .REG_AW(5), .PC_RESET(PCR)) dut (
    .CLK(CLK), .RST_n(RST_n), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_pc_i(id_pc_i), .id_rs1_data_i(id_rs1_data_i),
    .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i), .id_rs1_i(id_rs1_i),
    .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i), .id_alu_ctrl_i(id_alu_ctrl_i),
    .id_asel_i(id_asel_i), .id_bsel_i(id_bsel_i), .id_ctrl_i(id_ctrl_i),
    .exm_regwrite_i(exm_regwrite_i), .exm_rd_i(exm_rd_i), .exm_data_i(exm_data_i),
    .mwb_regwrite_i(mwb_regwrite_i), .mwb_rd_i(mwb_rd_i), .mwb_data_i(mwb_data_i),
    .A_alu(A_alu), .B_alu(B_alu), .control_alu(control_alu), .ex_valid_o(ex_valid_o),
    .ex_pc_o(ex_pc_o), .ex_store_data_o(ex_store_data_o), .ex_rd_o(ex_rd_o),
    .ex_ctrl_o(ex_ctrl_o), .load_use_stall_o(load_use_stall_o)
  );

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic drive_id(input logic v, input logic [31:0] pc, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] imm, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic [4:0] alu,
                          input logic [1:0] asel, input logic bsel, input logic [4:0] ctrl);
    id_valid_i = v; id_pc_i = pc; id_rs1_data_i = d1; id_rs2_data_i = d2; id_imm_i = imm;
    id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd; id_alu_ctrl_i = alu;
    id_asel_i = asel; id_bsel_i = bsel; id_ctrl_i = ctrl;
  endtask

  task automatic clear_wb();
    exm_regwrite_i = 0; exm_rd_i = 0; exm_data_i = 0;
    mwb_regwrite_i = 0; mwb_rd_i = 0; mwb_data_i = 0;
  endtask

  task automatic test_reset();
    stall_i = 0; flush_i = 0; clear_wb();
    drive_id(1'($urandom), $urandom, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom),
             5'($urandom), 5'($urandom), 2'($urandom), 1'($urandom), 5'($urandom));
    RST_n = 0;
    step(); step();
    checks++; if (ex_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", ex_valid_o); end
    checks++; if (ex_ctrl_o !== 5'b0) begin errors++; $display("FAIL rst_ctrl: got %b exp 0", ex_ctrl_o); end
    checks++; if (ex_pc_o !== PCR) begin errors++; $display("FAIL rst_pc: got %h exp %h", ex_pc_o, PCR); end
    checks++; if (control_alu !== 5'b0) begin errors++; $display("FAIL rst_alu: got %h exp 0", control_alu); end
    checks++; if (A_alu !== 32'h0 || B_alu !== 32'h0) begin errors++; $display("FAIL rst_ab: got %h/%h exp 0/0", A_alu, B_alu); end
    checks++; if (ex_rd_o !== 5'd0) begin errors++; $display("FAIL rst_rd: got %0d exp 0", ex_rd_o); end
    RST_n = 1;
  endtask

  task automatic test_capture();
    clear_wb();
    // ADDI x5, x1, 7
    drive_id(1, 32'h40, 32'd10, 32'h33, 32'd7, 5'd1, 5'd0, 5'd5, 5'd0, 2'd0, 1'b1, 5'b10000);
    step();
    checks++; if (A_alu !== 32'd10) begin errors++; $display("FAIL cap_A: got %h exp %h", A_alu, 32'd10); end
    checks++; if (B_alu !== 32'd7) begin errors++; $display("FAIL cap_B: got %h exp %h", B_alu, 32'd7); end
    checks++; if (ex_rd_o !== 5'd5) begin errors++; $display("FAIL cap_rd: got %0d exp 5", ex_rd_o); end
    checks++; if (ex_ctrl_o !== 5'b10000) begin errors++; $display("FAIL cap_ctrl: got %b exp 10000", ex_ctrl_o); end
    checks++; if (ex_valid_o !== 1'b1 || ex_pc_o !== 32'h40) begin errors++; $display("FAIL cap_vpc: got %b/%h exp 1/40", ex_valid_o, ex_pc_o); end
    checks++; if (ex_store_data_o !== 32'h33) begin errors++; $display("FAIL cap_st: got %h exp 33", ex_store_data_o); end
    // AUIPC-style: A=PC, B=imm
    drive_id(1, 32'h44, 32'h1, 32'h2, 32'h1000, 5'd0, 5'd0, 5'd6, 5'd0, 2'd1, 1'b1, 5'b10000);
    step();
    checks++; if (A_alu !== 32'h44 || B_alu !== 32'h1000) begin errors++; $display("FAIL cap_pc: got %h/%h exp 44/1000", A_alu, B_alu); end
    // LUI-style: A=zero, and reserved select 3 also reads zero
    drive_id(1, 32'h48, 32'h77, 32'h2, 32'h2000, 5'd1, 5'd0, 5'd7, 5'd0, 2'd2, 1'b1, 5'b10000);
    step();
    checks++; if (A_alu !== 32'h0) begin errors++; $display("FAIL cap_zero: got %h exp 0", A_alu); end
    drive_id(1, 32'h4c, 32'h77, 32'h2, 32'h2000, 5'd1, 5'd0, 5'd7, 5'd0, 2'd3, 1'b1, 5'b10000);
    step();
    checks++; if (A_alu !== 32'h0) begin errors++; $display("FAIL cap_rsv: got %h exp 0", A_alu); end
    // SUB x8, x2, x3
    drive_id(1, 32'h50, 32'h100, 32'h30, 32'h9, 5'd2, 5'd3, 5'd8, 5'd1, 2'd0, 1'b0, 5'b10000);
    step();
    checks++; if (A_alu !== 32'h100 || B_alu !== 32'h30) begin errors++; $display("FAIL cap_rr: got %h/%h exp 100/30", A_alu, B_alu); end
    checks++; if (control_alu !== 5'd1) begin errors++; $display("FAIL cap_alu: got %h exp 1", control_alu); end
    // Invalid decode slot: ctrl and rd forced to zero
    drive_id(0, 32'h54, 32'h1, 32'h2, 32'h3, 5'd2, 5'd3, 5'd9, 5'd2, 2'd0, 1'b0, 5'b11111);
    step();
    checks++; if (ex_valid_o !== 1'b0 || ex_ctrl_o !== 5'b0 || ex_rd_o !== 5'd0) begin errors++; $display("FAIL cap_inv: got v=%b c=%b rd=%0d exp 0/0/0", ex_valid_o, ex_ctrl_o, ex_rd_o); end
  endtask

  task automatic test_forwarding();
    logic [31:0] exp;
    clear_wb();
    drive_id(1, 32'h60, 32'h11, 32'h22, 32'h0, 5'd3, 5'd7, 5'd12, 5'd0, 2'd0, 1'b0, 5'b10000);
    step();
    exm_regwrite_i = 1; exm_rd_i = 3; exm_data_i = 32'hAA;
    mwb_regwrite_i = 1; mwb_rd_i = 3; mwb_data_i = 32'hBB;
    #1;
    exp = FWD_ON ? 32'hAA : 32'h11;
    checks++; if (A_alu !== exp) begin errors++; $display("FAIL fwd_prio: got %h exp %h", A_alu, exp); end
    exm_regwrite_i = 0; #1;
    exp = FWD_ON ? 32'hBB : 32'h11;
    checks++; if (A_alu !== exp) begin errors++; $display("FAIL fwd_mwb: got %h exp %h", A_alu, exp); end
    // rs2 from MEM/WB feeds both B and store data
    mwb_rd_i = 7; mwb_data_i = 32'hCC; #1;
    exp = FWD_ON ? 32'hCC : 32'h22;
    checks++; if (B_alu !== exp || ex_store_data_o !== exp) begin errors++; $display("FAIL fwd_rs2: got %h/%h exp %h", B_alu, ex_store_data_o, exp); end
    // store data still forwarded when B selects imm
    drive_id(1, 32'h64, 32'h11, 32'h22, 32'h8, 5'd3, 5'd7, 5'd0, 5'd0, 2'd0, 1'b1, 5'b00100);
    step();
    checks++; if (B_alu !== 32'h8 || ex_store_data_o !== exp) begin errors++; $display("FAIL fwd_st: got %h/%h exp 8/%h", B_alu, ex_store_data_o, exp); end
    // x0 never forwarded
    clear_wb();
    drive_id(1, 32'h68, 32'h55, 32'h0, 32'h0, 5'd0, 5'd0, 5'd13, 5'd0, 2'd0, 1'b0, 5'b10000);
    step();
    exm_regwrite_i = 1; exm_rd_i = 0; exm_data_i = 32'hAA;
    mwb_regwrite_i = 1; mwb_rd_i = 0; mwb_data_i = 32'hBB;
    #1;
    checks++; if (A_alu !== 32'h55) begin errors++; $display("FAIL fwd_x0: got %h exp 55", A_alu); end
    checks++; if (load_use_stall_o !== 1'b0) begin errors++; $display("FAIL fwd_x0_stall: got %b exp 0", load_use_stall_o); end
    clear_wb();
  endtask

  task automatic test_load_use();
    clear_wb();
    // LW x4 enters EX; next decode reads rs2=x4
    drive_id(1, 32'h70, 32'h0, 32'h0, 32'h4, 5'd1, 5'd0, 5'd4, 5'd0, 2'd0, 1'b1, 5'b11010);
    step();
    id_rs1_i = 9; id_rs2_i = 4; #1;
    checks++; if (load_use_stall_o !== 1'b1) begin errors++; $display("FAIL lu_hit: got %b exp 1", load_use_stall_o); end
    id_rs2_i = 5; #1;
    checks++; if (load_use_stall_o !== 1'b0) begin errors++; $display("FAIL lu_miss: got %b exp 0", load_use_stall_o); end
    // LW x0 never stalls
    drive_id(1, 32'h74, 32'h0, 32'h0, 32'h4, 5'd1, 5'd0, 5'd0, 5'd0, 2'd0, 1'b1, 5'b11010);
    step();
    id_rs1_i = 0; id_rs2_i = 0; #1;
    checks++; if (load_use_stall_o !== 1'b0) begin errors++; $display("FAIL lu_x0: got %b exp 0", load_use_stall_o); end
  endtask

  task automatic test_raw_stall();
    logic [31:0] exp;
    logic        exps;
    clear_wb();
    drive_id(1, 32'h78, 32'h66, 32'h67, 32'h0, 5'd6, 5'd11, 5'd10, 5'd0, 2'd0, 1'b0, 5'b10000);
    step();
    exm_regwrite_i = 1; exm_rd_i = 6; exm_data_i = 32'h99; #1;
    exp = FWD_ON ? 32'h99 : 32'h66; exps = !FWD_ON;
    checks++; if (A_alu !== exp) begin errors++; $display("FAIL raw_A: got %h exp %h", A_alu, exp); end
    checks++; if (load_use_stall_o !== exps) begin errors++; $display("FAIL raw_exm: got %b exp %b", load_use_stall_o, exps); end
    clear_wb(); mwb_regwrite_i = 1; mwb_rd_i = 11; mwb_data_i = 32'h88; #1;
    checks++; if (load_use_stall_o !== exps) begin errors++; $display("FAIL raw_mwb: got %b exp %b", load_use_stall_o, exps); end
    clear_wb(); id_rs1_i = 10; #1;
    checks++; if (load_use_stall_o !== exps) begin errors++; $display("FAIL raw_ex: got %b exp %b", load_use_stall_o, exps); end
    id_rs1_i = 0; id_rs2_i = 0; exm_regwrite_i = 1; exm_rd_i = 0; #1;
    checks++; if (load_use_stall_o !== 1'b0) begin errors++; $display("FAIL raw_x0: got %b exp 0", load_use_stall_o); end
    clear_wb();
  endtask

  task automatic test_stall_flush();
    clear_wb();
    drive_id(1, 32'h80, 32'h1234, 32'h0, 32'h5, 5'd1, 5'd0, 5'd9, 5'd3, 2'd0, 1'b1, 5'b10000);
    step();
    drive_id(1, 32'h84, 32'hFFFF, 32'h1, 32'h6, 5'd2, 5'd0, 5'd12, 5'd7, 2'd0, 1'b1, 5'b10000);
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (ex_pc_o !== 32'h80 || ex_rd_o !== 5'd9 || A_alu !== 32'h1234 || control_alu !== 5'd3)
        begin errors++; $display("FAIL stall_hold%0d: got pc=%h rd=%0d A=%h alu=%0d exp 80/9/1234/3", i, ex_pc_o, ex_rd_o, A_alu, control_alu); end
    end
    flush_i = 1; step();
    checks++; if (ex_valid_o !== 1'b0 || ex_ctrl_o !== 5'b0 || ex_rd_o !== 5'd0 || control_alu !== 5'd0)
      begin errors++; $display("FAIL flush_bubble: got v=%b c=%b rd=%0d alu=%0d exp 0", ex_valid_o, ex_ctrl_o, ex_rd_o, control_alu); end
    flush_i = 0; stall_i = 0; step();
    checks++; if (ex_pc_o !== 32'h84 || ex_valid_o !== 1'b1) begin errors++; $display("FAIL resume: got %h/%b exp 84/1", ex_pc_o, ex_valid_o); end
    stall_i = 1; RST_n = 0; step();
    checks++; if (ex_valid_o !== 1'b0 || ex_pc_o !== PCR || ex_ctrl_o !== 5'b0)
      begin errors++; $display("FAIL rst_stall: got v=%b pc=%h c=%b exp 0/%h/0", ex_valid_o, ex_pc_o, ex_ctrl_o, PCR); end
    RST_n = 1; stall_i = 0;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_forwarding();
    test_load_use();
    test_raw_stall();
    test_stall_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
